// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file, the decoder and the hazard unit.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;

    // Low bit index of port `port` inside a flat bus of `w`-bit lanes.
    function automatic int slice_lo(input int port, input int w);
        return port * w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: write ports, read ports and issue/scoreboard signals.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [NWR-1:0]        we;
    logic [NWR*AW-1:0]     wa;
    logic [NWR*DATA_W-1:0] wd;
    logic [NRD*AW-1:0]     ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_v;
    logic [AW-1:0]         iss_rd;
    logic [CW-1:0]         busy_cnt;

    modport master (
        output we, wa, wd, ra, iss_v, iss_rd,
        input  rd, rd_busy, busy_cnt
    );

    modport slave (
        input  we, wa, wd, ra, iss_v, iss_rd,
        output rd, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-destination tracker: busy bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    rd_busy,
    output logic [CW-1:0]     busy_cnt
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [AW-1:0]    wa_a [NWR];
    logic [AW-1:0]    ra_a [NRD];

    for (genvar k = 0; k < NWR; k++) begin : g_wa
        assign wa_a[k] = wa[slice_lo(k, AW) +: AW];
    end

    for (genvar j = 0; j < NRD; j++) begin : g_ra
        assign ra_a[j] = ra[slice_lo(j, AW) +: AW];
    end

    // Clears first, then the issue set, so a re-issued destination stays pending.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) busy_nxt[wa_a[k]] = 1'b0;
        end
        if (iss_v) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // A same-cycle writeback hides the busy flag when its data is being bypassed.
    always_comb begin
        rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            rd_busy[j] = busy[ra_a[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && wa_a[k] == ra_a[j]) rd_busy[j] = 1'b0;
                end
            end
            if (ra_a[j] == '0) rd_busy[j] = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write register file with r0 hardwired to zero and an issue scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] mem  [NREGS];
    logic [AW-1:0]     wa_a [NWR];
    logic [DATA_W-1:0] wd_a [NWR];
    logic [AW-1:0]     ra_a [NRD];
    logic [DATA_W-1:0] rd_a [NRD];

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa_a[k] = bus.wa[slice_lo(k, AW) +: AW];
        assign wd_a[k] = bus.wd[slice_lo(k, DATA_W) +: DATA_W];
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        assign ra_a[j] = bus.ra[slice_lo(j, AW) +: AW];
        assign bus.rd[slice_lo(j, DATA_W) +: DATA_W] = rd_a[j];
    end

    // Ascending port loop: the last non-blocking write, i.e. the highest port, wins a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.we[k] && wa_a[k] != '0) mem[wa_a[k]] <= wd_a[k];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_a[j] = mem[ra_a[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (bus.we[k] && wa_a[k] == ra_a[j]) rd_a[j] = wd_a[k];
                end
            end
            if (ra_a[j] == '0) rd_a[j] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bus.we),
        .wa       (bus.wa),
        .iss_v    (bus.iss_v),
        .iss_rd   (bus.iss_rd),
        .ra       (bus.ra),
        .rd_busy  (bus.rd_busy),
        .busy_cnt (bus.busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: one BYPASS=1 and one BYPASS=0 register file driven in lockstep against a reference model.
module tb_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) b1 ();
    regfile_mp_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) b0 ();

    regfile_mp #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    regfile_mp #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));

    // applied inputs (t_*) and staged inputs for the next cycle (s_*)
    logic [NWR-1:0]        t_we, s_we;
    logic [NWR*AW-1:0]     t_wa, s_wa;
    logic [NWR*DATA_W-1:0] t_wd, s_wd;
    logic [NRD*AW-1:0]     t_ra, s_ra;
    logic                  t_iss_v, s_iss_v;
    logic [AW-1:0]         t_iss_rd, s_iss_rd;
    logic                  s_rst_n;

    assign b1.we = t_we;  assign b1.wa = t_wa;  assign b1.wd = t_wd;  assign b1.ra = t_ra;
    assign b1.iss_v = t_iss_v;  assign b1.iss_rd = t_iss_rd;
    assign b0.we = t_we;  assign b0.wa = t_wa;  assign b0.wd = t_wd;  assign b0.ra = t_ra;
    assign b0.iss_v = t_iss_v;  assign b0.iss_rd = t_iss_rd;

    typedef struct {
        int                    id;
        logic [NRD*DATA_W-1:0] rd1;
        logic [NRD*DATA_W-1:0] rd0;
        logic [NRD-1:0]        rb1;
        logic [NRD-1:0]        rb0;
        logic [CW-1:0]         bc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc_id = 0;
    bit   mvalid = 0;

    logic [DATA_W-1:0] m_mem  [NREGS];
    bit                m_busy [NREGS];

    task automatic cmp(input string nm, input int id, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, id, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so compare once per cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("rd_bypass",      e.id, 256'(b1.rd),       256'(e.rd1));
                cmp("rd_nobypass",    e.id, 256'(b0.rd),       256'(e.rd0));
                cmp("busy_bypass",    e.id, 256'(b1.rd_busy),  256'(e.rb1));
                cmp("busy_nobypass",  e.id, 256'(b0.rd_busy),  256'(e.rb0));
                cmp("busy_cnt",       e.id, 256'(b1.busy_cnt), 256'(e.bc));
                cmp("busy_cnt_nobyp", e.id, 256'(b0.busy_cnt), 256'(e.bc));
            end
        end
    end

    // Reference model: expected outputs from the current state and the applied inputs.
    task automatic model_expect(output exp_t e);
        int a, hit, c;
        e.id = cyc_id;
        e.rd1 = '0; e.rd0 = '0; e.rb1 = '0; e.rb0 = '0;
        for (int j = 0; j < NRD; j++) begin
            a = int'(t_ra[j*AW +: AW]);
            hit = -1;
            for (int k = NWR - 1; k >= 0; k--)
                if (hit < 0 && t_we[k] && int'(t_wa[k*AW +: AW]) == a) hit = k;
            if (a != 0) begin
                e.rd0[j*DATA_W +: DATA_W] = m_mem[a];
                e.rd1[j*DATA_W +: DATA_W] = (hit >= 0) ? t_wd[hit*DATA_W +: DATA_W] : m_mem[a];
                e.rb0[j] = m_busy[a];
                e.rb1[j] = m_busy[a] && (hit < 0);
            end
        end
        c = 0;
        for (int i = 0; i < NREGS; i++) if (m_busy[i]) c++;
        e.bc = CW'(c);
    endtask

    task automatic model_update();
        int a;
        if (!s_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
            mvalid = 1;
            return;
        end
        for (int k = 0; k < NWR; k++) begin
            a = int'(t_wa[k*AW +: AW]);
            if (t_we[k] && a != 0) m_mem[a] = t_wd[k*DATA_W +: DATA_W];
            if (t_we[k]) m_busy[a] = 0;
        end
        if (t_iss_v && t_iss_rd != '0) m_busy[int'(t_iss_rd)] = 1;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = s_rst_n;
        t_we = s_we; t_wa = s_wa; t_wd = s_wd; t_ra = s_ra;
        t_iss_v = s_iss_v; t_iss_rd = s_iss_rd;
        cyc_id++;
        if (mvalid) begin
            model_expect(e);
            q.push_back(e);
        end
        model_update();
    endtask

    task automatic idle();
        s_rst_n = 1'b1; s_we = '0; s_wa = '0; s_wd = '0; s_ra = '0;
        s_iss_v = 1'b0; s_iss_rd = '0;
    endtask

    task automatic set_wr(input int k, input int a, input logic [DATA_W-1:0] d);
        if (k < NWR) begin
            s_we[k] = 1'b1;
            s_wa[k*AW +: AW] = AW'(a);
            s_wd[k*DATA_W +: DATA_W] = d;
        end
    endtask

    task automatic set_rd(input int j, input int a);
        if (j < NRD) s_ra[j*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        s_iss_v = 1'b1; s_iss_rd = AW'(a);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(); s_rst_n = 1'b0;
        step(); step();

        // reset state across every address
        for (int a = 0; a < NREGS; a++) begin
            idle();
            for (int j = 0; j < NRD; j++) set_rd(j, (a + j) % NREGS);
            step();
        end

        // r0 ignores writes
        idle(); set_wr(0, 0, DATA_W'(32'hDEADBEEF)); set_rd(0, 0); step();
        idle(); set_rd(0, 0); set_rd(1, 0); step();

        // same-cycle bypass vs stored value
        idle(); set_wr(0, 5, DATA_W'(32'h1234)); set_rd(0, 5); step();
        idle(); set_rd(0, 5); step();

        // write collision on r7: highest port wins
        idle(); set_wr(0, 7, DATA_W'(32'hAAAA)); set_wr(1, 7, DATA_W'(32'h5555)); set_rd(0, 7); step();
        idle(); set_rd(0, 7); step();

        // scoreboard issue / writeback / simultaneous set+clear
        idle(); issue(3); set_rd(0, 3); step();
        idle(); issue(9); set_rd(0, 3); set_rd(1, 9); step();
        idle(); set_rd(0, 3); set_rd(1, 9); step();
        idle(); set_wr(0, 3, DATA_W'(32'h33)); set_rd(0, 3); set_rd(1, 9); step();
        idle(); issue(9); set_wr(0, 9, DATA_W'(32'h99)); set_rd(0, 9); set_rd(1, 3); step();
        idle(); set_rd(0, 9); set_rd(1, 3); step();

        // reset mid-operation with writes and an issue pending
        foreach (m_busy[i]) if (i == 1 || i == 2 || i == 4 || i == 6) begin
            idle(); issue(i); set_wr(0, i + 8, rnd_data()); step();
        end
        idle(); s_rst_n = 1'b0; s_we = '1;
        set_wr(0, 10, DATA_W'(32'h1010)); set_wr(1, 11, DATA_W'(32'h1111));
        if (NWR > 2) for (int k = 2; k < NWR; k++) set_wr(k, 12, DATA_W'(32'h1212));
        issue(12); set_rd(0, 1); set_rd(1, 10); step();
        for (int a = 0; a < NREGS; a++) begin
            idle();
            for (int j = 0; j < NRD; j++) set_rd(j, (a + j) % NREGS);
            step();
        end

        // randomized traffic, addresses often confined to a few registers to force hazards
        for (int n = 0; n < 400; n++) begin
            int lim;
            idle();
            lim = ($urandom_range(0, 1) == 1) ? 3 : NREGS - 1;
            for (int k = 0; k < NWR; k++)
                if ($urandom_range(0, 2) != 0) set_wr(k, $urandom_range(0, lim), rnd_data());
            for (int j = 0; j < NRD; j++) set_rd(j, $urandom_range(0, lim));
            if ($urandom_range(0, 1) == 1) issue($urandom_range(0, lim));
            if ($urandom_range(0, 59) == 0) s_rst_n = 1'b0;
            step();
        end

        idle();
        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        cmp("queue_drain", cyc_id, 256'(q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipeline CPU, successor to the fixed 32x32 2R/1W file. Adds configurable width, depth, and read/write port counts. Adds a synchronous clear, same-cycle write-to-read bypass, and an issue/writeback scoreboard that flags pending destinations to the hazard unit. It sits between decode (reads, issue) and writeback (writes). Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers; power of two, ≥ 2
- NRD, 2, read ports
- NWR, 2, write ports
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value
- AW (localparam), $clog2(NREGS), address width
- CW (localparam), $clog2(NREGS+1), busy-count width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- we  in  NWR  per-port write enable
- wa  in  NWR*AW  write addresses; port k at [k*AW +: AW]
- wd  in  NWR*DATA_W  write data; port k at [k*DATA_W +: DATA_W]
- ra  in  NRD*AW  read addresses; port j at [j*AW +: AW]
- rd  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  register at ra[j] has an outstanding write, combinational
- iss_v  in  1  issue: mark iss_rd pending
- iss_rd  in  AW  destination being issued
- busy_cnt  out  CW  number of pending registers, registered

## Operation
- Storage: NREGS x DATA_W. Reset (rst_n=0 at posedge) clears every register and busy bit in one cycle. Register 0 ignores writes and always reads 0.
- Write: at posedge, for each k with we[k]=1 and wa[k]≠0, reg[wa[k]] ← wd[k]. If ports collide on one address, the highest enabled index wins.
- Read, port j:
  - ra[j]=0 → 0.
  - BYPASS=1 and some enabled write port targets ra[j] this cycle → that port's wd, highest index winning.
  - Otherwise → stored value.
- Scoreboard: one busy bit per register; busy[0] is constant 0.
  - Clear: at posedge, busy[a] is cleared if any enabled write port targets a.
  - Set: at posedge, busy[iss_rd] is set if iss_v=1 and iss_rd≠0.
  - Set and clear on the same address in the same cycle: set wins, because the new producer is still outstanding.
- rd_busy[j] = busy[ra[j]].
  - BYPASS=1: forced to 0 when a same-cycle write to ra[j] exists, because the bypassed data is valid.
  - BYPASS=0: no masking.
  - ra[j]=0 → 0.
- busy_cnt is registered and equals popcount(busy) after each posedge update. It is recomputed from the next-state busy vector, not incremented.

## Timing
- Read latency 0 (combinational from ra, we, wa, wd, and state).
- Write latency 1: data is visible through storage from the cycle after the write edge; with BYPASS=1 it is also visible in the same cycle.
- Issue → rd_busy=1 from the cycle after the iss_v edge. Writeback clears busy at its edge.
- Reset values:
  - all registers 0
  - busy 0, so rd_busy 0 and busy_cnt 0
  - rd 0 for every address
- Reset asserted mid-operation overrides same-cycle we and iss_v: nothing is written and nothing is marked.
- Combinational paths exist from we/wa/wd to rd/rd_busy only when BYPASS=1.
- No combinational path from iss_v/iss_rd to any output.

## Structure
- Package regfile_pkg: helper function for port-slice extraction and the DATA_W/NREGS default constants shared with decode and hazard logic.
- Sub-module regfile_scoreboard: busy vector, set/clear priority, busy_cnt popcount, rd_busy lookup with the bypass mask. It takes we/wa, iss_v/iss_rd, ra, and BYPASS.
- Top level holds storage, the write-collision priority mux, and the read/bypass muxes.

## Test plan
- Reset, then read all 32 addresses on both ports → rd=0, rd_busy=0, busy_cnt=0. Write 0xDEADBEEF to r0 → r0 still reads 0.
- Same-cycle bypass: we[0]=1, wa[0]=5, wd[0]=0x1234, ra[0]=5.
  - BYPASS=1 → rd0=0x1234 that cycle.
  - BYPASS=0 → old value 0, then 0x1234 next cycle.
- Write collision: both ports write r7 (port0 0xAAAA, port1 0x5555) → r7 reads 0x5555 next cycle; bypass read that cycle also 0x5555.
- Scoreboard:
  - Issue r3, r9 on consecutive cycles → busy_cnt 1 then 2, rd_busy=1 on both.
  - Writeback r3 → busy_cnt 1, r3 not busy.
  - In one cycle, issue r9 while writing r9 → r9 stays busy, busy_cnt stays 1.
- Reset mid-operation: with 4 registers busy and writes pending, assert rst_n=0 for one edge with we=11, iss_v=1 → all registers 0, busy_cnt 0, no writes or marks land.
- Parametrisation: re-run the suite at DATA_W=64, NREGS=16, NRD=3, NWR=1 → identical pass criteria with widths scaled.
